// File: rtl/decode.sv
// Instruction-decode stage: holds one fetched instruction, reads two operands,
// decodes a MIPS-I subset onto the execute bus and redirects fetch on taken transfers.
module decode #(
  parameter logic [29:0] RESET_PC = 30'd0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [61:0]  IF_ID_BUS,
  input  logic         if_valid,
  output logic         id_allow_in,
  output logic [4:0]   rf_raddr1,
  output logic [4:0]   rf_raddr2,
  input  logic [31:0]  rf_rdata1,
  input  logic [31:0]  rf_rdata2,
  input  logic         ex_allow_in,
  output logic         id_valid,
  output logic [137:0] ID_EX_BUS,
  output logic         jump_taken,
  output logic [29:0]  jump_target
);

  localparam int unsigned PC_W   = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLL   = 4'd6;
  localparam logic [3:0] ALU_SRL   = 4'd7;
  localparam logic [3:0] ALU_PASSB = 4'd8;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } id_ex_t;

  logic [0:0]        state_q, state_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic              hold_valid_q, hold_valid_d;
  logic [PC_W-1:0]   hold_pc_q, hold_pc_d;
  logic [DATA_W-1:0] hold_instr_q, hold_instr_d;

  logic [5:0]        opcode_c, funct_c;
  logic [REG_W-1:0]  rt_c, rd_c, sa_c;
  logic [DATA_W-1:0] simm_c, zimm_c;
  logic [PC_W-1:0]   pc_inc_c;
  id_ex_t            bus_c;
  logic              taken_c;
  logic [PC_W-1:0]   target_c;
  logic              accept_c, leave_c, redirecting_c;
  logic [PC_W-1:0]   fetch_pc_c, expect_pc_c;

  assign opcode_c = hold_instr_q[31:26];
  assign funct_c  = hold_instr_q[5:0];
  assign rt_c     = hold_instr_q[20:16];
  assign rd_c     = hold_instr_q[15:11];
  assign sa_c     = hold_instr_q[10:6];
  assign simm_c   = {{16{hold_instr_q[15]}}, hold_instr_q[15:0]};
  assign zimm_c   = {16'd0, hold_instr_q[15:0]};
  assign pc_inc_c = hold_pc_q + PC_W'(1);

  assign rf_raddr1   = hold_instr_q[25:21];
  assign rf_raddr2   = rt_c;
  assign id_valid    = hold_valid_q;
  assign id_allow_in = !hold_valid_q || ex_allow_in;
  assign ID_EX_BUS   = bus_c;
  assign jump_taken  = hold_valid_q && ex_allow_in && taken_c && (state_q == ST_RUN);
  assign jump_target = jump_taken ? target_c : '0;

  // Decode of the held instruction; an empty register decodes as a NOP.
  always_comb begin : decode_c
    bus_c    = '0;
    bus_c.pc = hold_pc_q;
    taken_c  = 1'b0;
    target_c = '0;
    if (hold_valid_q) begin
      case (opcode_c)
        6'h00: begin
          case (funct_c)
            6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A: begin
              bus_c.src_a     = rf_rdata1;
              bus_c.src_b     = rf_rdata2;
              bus_c.dest      = rd_c;
              bus_c.reg_write = 1'b1;
              case (funct_c)
                6'h21:   bus_c.alu_op = ALU_ADD;
                6'h23:   bus_c.alu_op = ALU_SUB;
                6'h24:   bus_c.alu_op = ALU_AND;
                6'h25:   bus_c.alu_op = ALU_OR;
                6'h26:   bus_c.alu_op = ALU_XOR;
                default: bus_c.alu_op = ALU_SLT;
              endcase
            end
            6'h00, 6'h02: begin
              bus_c.alu_op    = funct_c[1] ? ALU_SRL : ALU_SLL;
              bus_c.src_a     = rf_rdata2;
              bus_c.src_b     = DATA_W'(sa_c);
              bus_c.dest      = rd_c;
              bus_c.reg_write = 1'b1;
            end
            6'h08: begin
              taken_c  = 1'b1;
              target_c = rf_rdata1[31:2];
            end
            default: ;
          endcase
        end
        6'h09, 6'h23: begin
          bus_c.alu_op    = ALU_ADD;
          bus_c.src_a     = rf_rdata1;
          bus_c.src_b     = simm_c;
          bus_c.dest      = rt_c;
          bus_c.reg_write = 1'b1;
          bus_c.mem_read  = opcode_c[5];
        end
        6'h0D: begin
          bus_c.alu_op    = ALU_OR;
          bus_c.src_a     = rf_rdata1;
          bus_c.src_b     = zimm_c;
          bus_c.dest      = rt_c;
          bus_c.reg_write = 1'b1;
        end
        6'h0F: begin
          bus_c.alu_op    = ALU_PASSB;
          bus_c.src_b     = {hold_instr_q[15:0], 16'd0};
          bus_c.dest      = rt_c;
          bus_c.reg_write = 1'b1;
        end
        6'h2B: begin
          bus_c.alu_op     = ALU_ADD;
          bus_c.src_a      = rf_rdata1;
          bus_c.src_b      = simm_c;
          bus_c.store_data = rf_rdata2;
          bus_c.mem_write  = 1'b1;
        end
        6'h04, 6'h05: begin
          taken_c  = (rf_rdata1 == rf_rdata2) ^ opcode_c[0];
          target_c = pc_inc_c + simm_c[PC_W-1:0];
        end
        6'h02: begin
          taken_c  = 1'b1;
          target_c = {hold_pc_q[29:26], hold_instr_q[25:0]};
        end
        6'h03: begin
          taken_c         = 1'b1;
          target_c        = {hold_pc_q[29:26], hold_instr_q[25:0]};
          bus_c.alu_op    = ALU_PASSB;
          bus_c.src_b     = {pc_inc_c, 2'b00};
          bus_c.dest      = REG_W'(31);
          bus_c.reg_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fetch_pc_c    = IF_ID_BUS[61:32];
  assign accept_c      = if_valid && id_allow_in;
  assign leave_c       = hold_valid_q && ex_allow_in;
  // The jump cycle itself already filters the incoming instruction against the new target.
  assign redirecting_c = (state_q == ST_REDIRECT) || jump_taken;
  assign expect_pc_c   = jump_taken ? target_c : target_q;

  always_comb begin : next_state
    state_d      = state_q;
    target_d     = target_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    if (leave_c) hold_valid_d = 1'b0;
    if (jump_taken) target_d = target_c;
    if (accept_c && (!redirecting_c || fetch_pc_c == expect_pc_c)) begin
      hold_valid_d = 1'b1;
      hold_pc_d    = fetch_pc_c;
      hold_instr_d = IF_ID_BUS[31:0];
      state_d      = ST_RUN;
    end else if (jump_taken) begin
      state_d = ST_REDIRECT;
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state_q      <= ST_RUN;
      target_q     <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed scenarios plus a randomized run
// against a transaction-level model of the decode stage.
module tb_decode;

  logic         clk = 1'b0;
  logic         reset;
  logic [61:0]  IF_ID_BUS;
  logic         if_valid;
  logic         id_allow_in;
  logic [4:0]   rf_raddr1, rf_raddr2;
  logic [31:0]  rf_rdata1, rf_rdata2;
  logic         ex_allow_in;
  logic         id_valid;
  logic [137:0] ID_EX_BUS;
  logic         jump_taken;
  logic [29:0]  jump_target;

  logic [31:0]  rf [32];
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  decode #(.RESET_PC(30'd0)) dut (
    .clk(clk), .reset(reset), .IF_ID_BUS(IF_ID_BUS), .if_valid(if_valid),
    .id_allow_in(id_allow_in), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .ex_allow_in(ex_allow_in),
    .id_valid(id_valid), .ID_EX_BUS(ID_EX_BUS), .jump_taken(jump_taken),
    .jump_target(jump_target)
  );

  logic [29:0] o_pc;
  logic [3:0]  o_alu;
  logic [31:0] o_src_b;
  logic [4:0]  o_dest;
  logic        o_rw;
  assign o_pc    = ID_EX_BUS[137:108];
  assign o_alu   = ID_EX_BUS[107:104];
  assign o_src_b = ID_EX_BUS[71:40];
  assign o_dest  = ID_EX_BUS[7:3];
  assign o_rw    = ID_EX_BUS[2];

  function automatic logic [31:0] mk_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input int sa, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sa), 6'(fn)};
  endfunction

  function automatic logic [31:0] mk_j(input int op, input int idx);
    return {6'(op), 26'(idx)};
  endfunction

  // Expected execute bus for ADDIU r1,r0,5 at word address p (rf[0] is 0 here).
  function automatic logic [137:0] addiu_bus(input logic [29:0] p);
    return {p, 4'd0, 32'd0, 32'd5, 32'd0, 5'd1, 3'b100};
  endfunction

  // Reference decode written directly from the instruction table.
  function automatic void ref_decode(input bit v, input logic [29:0] pc, input logic [31:0] ins,
                                     input logic [31:0] r1, input logic [31:0] r2,
                                     output logic [137:0] bus, output bit tk, output logic [29:0] tgt);
    logic [3:0]  op;
    logic [31:0] a, b, sd, simm;
    logic [4:0]  d;
    bit          rw, mr, mw;
    int unsigned opc, fn;
    op = 0; a = 0; b = 0; sd = 0; d = 0; rw = 0; mr = 0; mw = 0; tk = 0; tgt = 0;
    opc  = ins[31:26];
    fn   = ins[5:0];
    simm = {{16{ins[15]}}, ins[15:0]};
    if (v) begin
      if (opc == 0 && (fn == 'h21 || fn == 'h23 || fn == 'h24 || fn == 'h25 || fn == 'h26 || fn == 'h2A)) begin
        a = r1; b = r2; d = ins[15:11]; rw = 1;
        case (fn)
          'h21: op = 0;
          'h23: op = 1;
          'h24: op = 2;
          'h25: op = 3;
          'h26: op = 4;
          default: op = 5;
        endcase
      end else if (opc == 0 && (fn == 0 || fn == 2)) begin
        a = r2; b = {27'd0, ins[10:6]}; d = ins[15:11]; rw = 1; op = (fn == 0) ? 4'd6 : 4'd7;
      end else if (opc == 0 && fn == 8) begin
        tk = 1; tgt = r1[31:2];
      end else begin
        case (opc)
          'h09: begin op = 0; a = r1; b = simm; d = ins[20:16]; rw = 1; end
          'h0D: begin op = 3; a = r1; b = {16'd0, ins[15:0]}; d = ins[20:16]; rw = 1; end
          'h0F: begin op = 8; b = {ins[15:0], 16'd0}; d = ins[20:16]; rw = 1; end
          'h23: begin op = 0; a = r1; b = simm; d = ins[20:16]; rw = 1; mr = 1; end
          'h2B: begin op = 0; a = r1; b = simm; sd = r2; mw = 1; end
          'h04: begin tk = (r1 == r2); tgt = pc + 30'd1 + simm[29:0]; end
          'h05: begin tk = (r1 != r2); tgt = pc + 30'd1 + simm[29:0]; end
          'h02: begin tk = 1; tgt = {pc[29:26], ins[25:0]}; end
          'h03: begin tk = 1; tgt = {pc[29:26], ins[25:0]}; d = 31; rw = 1; op = 8; b = {pc + 30'd1, 2'b00}; end
          default: ;
        endcase
      end
    end
    bus = {pc, op, a, b, sd, d, rw, mr, mw};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    int rs, rt, rd, sa, imm;
    k   = $urandom_range(0, 18);
    rs  = $urandom_range(0, 31);
    rt  = $urandom_range(0, 31);
    rd  = $urandom_range(0, 31);
    sa  = $urandom_range(0, 31);
    imm = $urandom_range(0, 65535);
    case (k)
      0: return mk_r(rs, rt, rd, sa, 'h21);
      1: return mk_r(rs, rt, rd, sa, 'h23);
      2: return mk_r(rs, rt, rd, sa, 'h24);
      3: return mk_r(rs, rt, rd, sa, 'h25);
      4: return mk_r(rs, rt, rd, sa, 'h26);
      5: return mk_r(rs, rt, rd, sa, 'h2A);
      6: return mk_r(rs, rt, rd, sa, 'h00);
      7: return mk_r(rs, rt, rd, sa, 'h02);
      8: return mk_i('h09, rs, rt, imm);
      9: return mk_i('h0D, rs, rt, imm);
      10: return mk_i('h0F, rs, rt, imm);
      11: return mk_i('h23, rs, rt, imm);
      12: return mk_i('h2B, rs, rt, imm);
      13: return mk_i('h04, rs, rt, int'($urandom_range(0, 8)) - 4);
      14: return mk_i('h05, rs, rt, int'($urandom_range(0, 8)) - 4);
      15: return mk_j('h02, $urandom_range(0, 255));
      16: return mk_j('h03, $urandom_range(0, 255));
      17: return mk_r(rs, rt, rd, sa, 'h08);
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [29:0] pc, input logic [31:0] ins, input bit ex);
    if_valid    = v;
    IF_ID_BUS   = {pc, ins};
    ex_allow_in = ex;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b1, 30'd9, 32'hFFFF_FFFF, 1'b1);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 30'd0, 32'd0, 1'b1);
    n_tests++;
    if ({id_valid, id_allow_in, jump_taken} !== 3'b010) begin
      n_fail++; $display("FAIL reset_flags got %b want 010", {id_valid, id_allow_in, jump_taken});
    end
    n_tests++;
    if (ID_EX_BUS !== 138'd0 || jump_target !== 30'd0) begin
      n_fail++; $display("FAIL reset_bus got %h/%h want 0/0", ID_EX_BUS, jump_target);
    end
  endtask

  task automatic test_stream();
    logic [31:0] addiu;
    addiu = mk_i('h09, 0, 1, 5);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 30'(i), addiu, 1'b1);
      n_tests++;
      if (id_valid !== (i != 0)) begin
        n_fail++; $display("FAIL stream_valid pc%0d got %b want %b", i, id_valid, i != 0);
      end
      if (i != 0) begin
        n_tests++;
        if (ID_EX_BUS !== addiu_bus(30'(i - 1))) begin
          n_fail++; $display("FAIL stream_bus pc%0d got %h want %h", i - 1, ID_EX_BUS, addiu_bus(30'(i - 1)));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] addiu;
    addiu = mk_i('h09, 0, 1, 5);
    drive(1'b1, 30'd4, addiu, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 30'd5, addiu, 1'b0);
      n_tests++;
      if (id_allow_in !== 1'b0 || id_valid !== 1'b1 || ID_EX_BUS !== addiu_bus(30'd4)) begin
        n_fail++; $display("FAIL stall_hold cyc%0d got allow=%b valid=%b bus=%h want 0/1/%h",
                           i, id_allow_in, id_valid, ID_EX_BUS, addiu_bus(30'd4));
      end
      tick();
    end
    drive(1'b1, 30'd5, addiu, 1'b1);
    n_tests++;
    if (id_allow_in !== 1'b1 || ID_EX_BUS !== addiu_bus(30'd4)) begin
      n_fail++; $display("FAIL stall_release got allow=%b bus=%h want 1/%h", id_allow_in, ID_EX_BUS, addiu_bus(30'd4));
    end
    tick();
    drive(1'b0, 30'd6, addiu, 1'b1);
    n_tests++;
    if (id_valid !== 1'b1 || ID_EX_BUS !== addiu_bus(30'd5)) begin
      n_fail++; $display("FAIL stall_next got valid=%b bus=%h want 1/%h", id_valid, ID_EX_BUS, addiu_bus(30'd5));
    end
    tick();
    drive(1'b0, 30'd6, addiu, 1'b1);
    n_tests++;
    if (id_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_drain got valid=%b want 0", id_valid);
    end
  endtask

  task automatic test_beq();
    bit          ev [7] = '{0, 1, 0, 0, 0, 1, 1};
    int          epc[7] = '{0, 10, 0, 0, 0, 14, 15};
    bit          ejt[7] = '{0, 1, 0, 0, 0, 0, 0};
    logic [31:0] ins;
    int          pulses;
    pulses = 0;
    do_reset();
    rf[1] = 32'd7;
    rf[2] = 32'd7;
    for (int i = 0; i < 7; i++) begin
      ins = (i == 0) ? mk_i('h04, 1, 2, 3) : mk_i('h09, 0, 1, 5);
      drive(1'b1, 30'(10 + i), ins, 1'b1);
      if (jump_taken === 1'b1) pulses++;
      n_tests++;
      if (id_valid !== ev[i] || jump_taken !== ejt[i] || jump_target !== (ejt[i] ? 30'd14 : 30'd0) ||
          (ev[i] && o_pc !== 30'(epc[i]))) begin
        n_fail++; $display("FAIL beq_seq pc%0d got v=%b jt=%b tgt=%0d pc=%0d want v=%b jt=%b tgt=%0d pc=%0d",
                           10 + i, id_valid, jump_taken, jump_target, o_pc, ev[i], ejt[i], ejt[i] ? 14 : 0, epc[i]);
      end
      tick();
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL beq_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_bne();
    do_reset();
    rf[1] = 32'd7;
    rf[2] = 32'd7;
    drive(1'b1, 30'd10, mk_i('h05, 1, 2, 3), 1'b1);
    tick();
    drive(1'b1, 30'd11, mk_i('h09, 0, 1, 5), 1'b1);
    n_tests++;
    if (jump_taken !== 1'b0 || id_valid !== 1'b1 || ID_EX_BUS !== {30'd10, 108'd0}) begin
      n_fail++; $display("FAIL bne_issue got jt=%b v=%b bus=%h want 0/1/%h", jump_taken, id_valid, ID_EX_BUS, {30'd10, 108'd0});
    end
    tick();
    drive(1'b0, 30'd12, 32'd0, 1'b1);
    n_tests++;
    if (id_valid !== 1'b1 || o_pc !== 30'd11) begin
      n_fail++; $display("FAIL bne_follow got v=%b pc=%0d want 1/11", id_valid, o_pc);
    end
    tick();
  endtask

  task automatic test_jal();
    do_reset();
    drive(1'b1, 30'h20, mk_j('h03, 'h40), 1'b1);
    tick();
    // Target arrives immediately after the jump: it must be loaded, not discarded.
    drive(1'b1, 30'h40, mk_i('h09, 0, 1, 5), 1'b1);
    n_tests++;
    if (jump_taken !== 1'b1 || jump_target !== 30'h40 || o_dest !== 5'd31 || o_src_b !== 32'h84 ||
        o_alu !== 4'd8 || o_rw !== 1'b1) begin
      n_fail++; $display("FAIL jal_decode got jt=%b tgt=%h dest=%0d b=%h alu=%0d rw=%b want 1/40/31/84/8/1",
                         jump_taken, jump_target, o_dest, o_src_b, o_alu, o_rw);
    end
    tick();
    drive(1'b0, 30'h41, 32'd0, 1'b1);
    n_tests++;
    if (id_valid !== 1'b1 || ID_EX_BUS !== addiu_bus(30'h40)) begin
      n_fail++; $display("FAIL jal_target_load got v=%b bus=%h want 1/%h", id_valid, ID_EX_BUS, addiu_bus(30'h40));
    end
    tick();
  endtask

  task automatic test_jr_reset();
    logic [31:0] addiu;
    addiu = mk_i('h09, 0, 1, 5);
    do_reset();
    rf[3] = 32'h100;
    drive(1'b1, 30'd5, mk_r(3, 0, 0, 0, 'h08), 1'b1);
    tick();
    drive(1'b1, 30'd6, addiu, 1'b1);
    n_tests++;
    if (jump_taken !== 1'b1 || jump_target !== 30'h40) begin
      n_fail++; $display("FAIL jr_target got jt=%b tgt=%h want 1/40", jump_taken, jump_target);
    end
    tick();
    drive(1'b1, 30'd7, addiu, 1'b1);
    n_tests++;
    if (id_valid !== 1'b0) begin
      n_fail++; $display("FAIL jr_discard got v=%b want 0", id_valid);
    end
    tick();
    reset = 1'b1;
    drive(1'b1, 30'd8, addiu, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b1, 30'd0, addiu, 1'b1);
    n_tests++;
    if ({id_valid, id_allow_in, jump_taken} !== 3'b010 || ID_EX_BUS !== 138'd0 || jump_target !== 30'd0) begin
      n_fail++; $display("FAIL jr_reset got flags=%b bus=%h tgt=%h want 010/0/0",
                         {id_valid, id_allow_in, jump_taken}, ID_EX_BUS, jump_target);
    end
    tick();
    drive(1'b0, 30'd1, addiu, 1'b1);
    n_tests++;
    if (id_valid !== 1'b1 || ID_EX_BUS !== addiu_bus(30'd0)) begin
      n_fail++; $display("FAIL jr_after_reset got v=%b bus=%h want 1/%h", id_valid, ID_EX_BUS, addiu_bus(30'd0));
    end
    tick();
  endtask

  task automatic test_random();
    bit          m_v, m_redir, pend;
    logic [29:0] m_pc, m_tgt, fpc, ptgt;
    logic [31:0] m_ins;
    do_reset();
    for (int i = 0; i < 32; i++) rf[i] = (i < 24) ? 32'($urandom_range(0, 3)) : $urandom;
    m_v = 0; m_redir = 0; pend = 0; m_pc = 0; m_tgt = 0; fpc = 0; ptgt = 0; m_ins = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0]  ins;
      bit           iv, ex, etk, eallow, ejt, acc, want_on;
      logic [137:0] ebus;
      logic [29:0]  etgt, want;
      ins = rand_instr();
      iv  = ($urandom_range(0, 3) != 0);
      ex  = ($urandom_range(0, 3) != 0);
      drive(iv, fpc, ins, ex);
      ref_decode(m_v, m_pc, m_ins, rf[m_ins[25:21]], rf[m_ins[20:16]], ebus, etk, etgt);
      eallow = !m_v || ex;
      ejt    = m_v && ex && etk && !m_redir;
      n_tests++;
      if ({id_valid, id_allow_in, jump_taken, jump_target, rf_raddr1, rf_raddr2, ID_EX_BUS} !==
          {m_v, eallow, ejt, ejt ? etgt : 30'd0, m_ins[25:21], m_ins[20:16], ebus}) begin
        n_fail++;
        $display("FAIL random cyc%0d got v=%b a=%b jt=%b tgt=%h ra=%0d/%0d bus=%h want v=%b a=%b jt=%b tgt=%h ra=%0d/%0d bus=%h",
                 c, id_valid, id_allow_in, jump_taken, jump_target, rf_raddr1, rf_raddr2, ID_EX_BUS,
                 m_v, eallow, ejt, ejt ? etgt : 30'd0, m_ins[25:21], m_ins[20:16], ebus);
      end
      acc     = iv && eallow;
      want_on = ejt || m_redir;
      want    = ejt ? etgt : m_tgt;
      if (m_v && ex) m_v = 0;
      if (acc && (!want_on || fpc == want)) begin
        m_v = 1; m_pc = fpc; m_ins = ins; m_redir = 0;
      end else if (ejt) begin
        m_redir = 1; m_tgt = etgt;
      end
      if (ejt) begin
        pend = 1; ptgt = etgt;
      end
      if (acc) begin
        if (pend && $urandom_range(0, 1) == 1) begin
          fpc = ptgt; pend = 0;
        end else begin
          fpc = fpc + 30'd1;
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    reset = 1'b1; if_valid = 1'b0; ex_allow_in = 1'b1; IF_ID_BUS = '0;
    test_reset();
    test_stream();
    test_stall();
    test_beq();
    test_bne();
    test_jal();
    test_jr_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

Instruction-decode stage: the consumer end of the 62-bit fetch-to-decode bus `{PC[29:0], instr[31:0]}`. It holds one instruction in its input register, reads two register-file operands, decodes a MIPS-I subset into the decode-to-execute bus, and redirects fetch on taken jumps and branches. Instructions fetched on the wrong path are discarded until the redirect target arrives. It sits between fetch and execute and provides fetch's `next_valid` back-pressure.

## Interface
- `RESET_PC`, default 0: word PC that fetch starts from; also the initial expected PC.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `IF_ID_BUS` input 62: `{PC[29:0], instr[31:0]}`.
- `if_valid` input 1: `IF_ID_BUS` holds a real instruction.
- `id_allow_in` output 1: decode accepts this cycle; drives fetch's `next_valid`.
- `rf_raddr1` / `rf_raddr2` output 5 each: `instr[25:21]` / `instr[20:16]` of the held instruction.
- `rf_rdata1` / `rf_rdata2` input 32 each: combinational register-file read data.
- `ex_allow_in` input 1: execute accepts this cycle.
- `id_valid` output 1: `ID_EX_BUS` is valid.
- `ID_EX_BUS` output 138, MSB first: `pc[29:0]`, `alu_op[3:0]`, `src_a[31:0]`, `src_b[31:0]`, `store_data[31:0]`, `dest[4:0]`, `reg_write`, `mem_read`, `mem_write`.
- `jump_taken` output 1: redirect fetch this cycle.
- `jump_target` output 30: word address to fetch next.

## Operation
- Input register: `hold_valid`, `hold_pc`, `hold_instr`.
- `id_allow_in = !hold_valid || ex_allow_in`.
- Accept when `if_valid && id_allow_in`.
- `id_valid = hold_valid`.
- The instruction leaves when `hold_valid && ex_allow_in`.
- States: RUN, REDIRECT (with a `target` register).
  - RUN: every accepted instruction is loaded.
  - A taken control transfer leaving in RUN pulses `jump_taken` for one cycle. That cycle, state goes to REDIRECT with `target <= jump_target`.
  - REDIRECT: accepted instructions with `PC != target` are discarded (`hold_valid` stays or becomes 0). The first with `PC == target` is loaded and state returns to RUN.
- Accepting and leaving in the same cycle is legal: the register reloads with no bubble.
- No delay slot.
- ALU ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL, 8 PASSB.
- Decode (rs=`[25:21]`, rt=`[20:16]`, rd=`[15:11]`, sa=`[10:6]`, imm=`[15:0]`):
  - ADDU/SUBU/AND/OR/XOR/SLT (funct 21/23/24/25/26/2A hex): A=rf1, B=rf2, dest=rd, reg_write.
  - SLL/SRL (funct 00/02): A=rf2, B=zero-extended sa, dest=rd, reg_write.
  - ADDIU (09): ADD, B=sign-ext imm, dest=rt, reg_write.
  - ORI (0D): OR, B=zero-ext imm, dest=rt, reg_write.
  - LUI (0F): PASSB, B={imm,16'b0}, dest=rt, reg_write.
  - LW (23): ADD, B=sign-ext imm, dest=rt, reg_write, mem_read.
  - SW (2B): ADD, B=sign-ext imm, store_data=rf2, mem_write.
  - BEQ/BNE (04/05): taken if rf1==rf2 / rf1!=rf2. Target = `hold_pc + 1 + sext(imm)`, 30-bit wrap. No register write.
  - J (02): target `{hold_pc[29:26], instr[25:0]}`.
  - JAL (03): same target as J; dest=31, reg_write, PASSB, B=`{hold_pc+1, 2'b00}`.
  - JR (funct 08): target `rf1[31:2]`.
  - Anything else: NOP. All control fields 0, dest 0, pc carried through.
- `jump_target` is 0 whenever `jump_taken` is 0.

## Timing
- Reset in the cycle it is sampled:
  - `hold_valid` 0, `id_valid` 0, state RUN, `target` = `RESET_PC`.
  - `id_allow_in` 1, `jump_taken` 0.
  - `hold_pc`, `hold_instr`, and therefore `ID_EX_BUS`, are 0.
- Reset mid-REDIRECT abandons the redirect.
- Latency: accepted at edge N, so `id_valid` is high after edge N.
- `jump_taken`, `jump_target`, `ID_EX_BUS` and `rf_raddr*` are combinational from the held register.
- `jump_taken = hold_valid && ex_allow_in && taken && state==RUN`.
- While `ex_allow_in` is 0, the held instruction and all outputs stay stable.
- A redirect arriving when the very next accepted PC already equals the target loads it immediately; nothing is discarded.

## Test plan
- Reset, then PCs 0..3 of ADDIU r1,r0,5 with `ex_allow_in`=1: `id_valid` high from the cycle after the first accept. Bus shows `alu_op`=0, `src_b`=5, `dest`=1, `reg_write`=1.
- `ex_allow_in` low for 3 cycles with PC 4 held: `id_allow_in`=0, `ID_EX_BUS` unchanged. PC 5 appears one cycle after release, with no loss or duplication.
- BEQ at PC 10, imm=+3, rf1=rf2=7: `jump_taken` pulses once with `jump_target`=14. PCs 11..13 are discarded (`id_valid`=0). PC 14 is then issued.
- BNE at PC 10 with equal operands: no `jump_taken`; PC 11 follows immediately.
- JAL at PC 0x20 with instr[25:0]=0x40: `jump_target`=0x40, dest=31, `src_b`=0x84.
- JR with rf1=0x100: target 0x40. Reset asserted while in REDIRECT: all outputs return to reset values and the next instruction, PC 0, is accepted in RUN.
